avalon_pkt_filter: RTL and testbench

Store-and-forward packet buffer between the MAC-side Avalon-ST source and the message decoder, which overlays t_dec_msg on the data bus.
- Accepts 64-bit Avalon-ST beats without backpressure.
- Holds each packet until its eop beat arrives.
- Forwards only complete, error-free packets; drops errored, malformed and overflowing packets and counts them.
- Guarantees the decoder never sees a partial or errored packet.

---
 rtl/t2t_pkg.sv | 24 ++
 rtl/avalon_pkt_ram.sv | 30 +++
 rtl/avalon_pkt_filter.sv | 168 ++++++++++++++++
 tb/tb_avalon_pkt_filter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/t2t_pkg.sv
// Shared beat format and write-side state encoding for the Avalon-ST packet filter.
`default_nettype none

package t2t_pkg;

    localparam int AV_DATA_WIDTH  = 64;
    localparam int AV_EMPTY_WIDTH = 3;

    typedef struct packed {
        logic [AV_DATA_WIDTH-1:0]  data;
        logic [AV_EMPTY_WIDTH-1:0] empty;
        logic                      sop;
        logic                      eop;
    } t_av_beat;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_IN_PKT  = 2'd1,
        WR_DISCARD = 2'd2
    } t_wr_state;

endpackage

`default_nettype wire

// File: rtl/avalon_pkt_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read (LUTRAM style).
`default_nettype none

module avalon_pkt_ram
    import t2t_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  t_av_beat      wdata,
    input  logic [AW-1:0] raddr,
    output t_av_beat      rdata
);

    t_av_beat mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/avalon_pkt_filter.sv
// Store-and-forward Avalon-ST buffer: only complete, error-free packets reach the output.
`default_nettype none

module avalon_pkt_filter
    import t2t_pkg::*;
#(
    parameter int DATA_WIDTH  = AV_DATA_WIDTH,
    parameter int EMPTY_WIDTH = AV_EMPTY_WIDTH,
    parameter int DEPTH       = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_startofpacket,
    input  logic                   in_endofpacket,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    input  logic                   in_error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_error,
    output logic [CNT_WIDTH-1:0]   drop_err_cnt,
    output logic [CNT_WIDTH-1:0]   drop_ovf_cnt
);

    localparam int           AW       = $clog2(DEPTH);
    localparam int           PW       = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    t_wr_state state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic out_valid_q, out_valid_d;
    t_av_beat out_beat_q, out_beat_d;

    logic [PW-1:0] base_wr;
    logic          pkt_active, pkt_ovf, full, we, load;
    logic [1:0]    ovf_inc;
    logic          err_inc;
    t_av_beat      wr_beat, rd_beat;
    logic [CNT_WIDTH:0] ovf_sum, err_sum;

    avalon_pkt_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (base_wr[AW-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_beat)
    );

    always_comb begin
        wr_beat.data  = in_data;
        wr_beat.empty = in_endofpacket ? in_empty : '0;
        wr_beat.sop   = in_startofpacket;
        wr_beat.eop   = in_endofpacket;
    end

    // A sop inside an open packet rewinds to the last commit before the new beat is placed.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        base_wr      = wr_ptr_q;
        pkt_active   = (state_q != WR_IDLE);
        pkt_ovf      = (state_q == WR_DISCARD);
        full         = 1'b0;
        we           = 1'b0;
        ovf_inc      = 2'd0;
        err_inc      = 1'b0;
        if (in_valid) begin
            if (in_startofpacket) begin
                if (pkt_active) begin
                    base_wr  = commit_ptr_q;
                    wr_ptr_d = commit_ptr_q;
                    ovf_inc  = 2'd1;
                end
                pkt_active = 1'b1;
                pkt_ovf    = 1'b0;
            end
            if (pkt_active) begin
                full = ((base_wr - rd_ptr_q) == FULL_LVL);
                if (in_endofpacket) begin
                    state_d = WR_IDLE;
                    if (pkt_ovf || full) begin
                        wr_ptr_d = commit_ptr_q;
                        ovf_inc  = ovf_inc + 2'd1;
                    end else if (in_error) begin
                        wr_ptr_d = commit_ptr_q;
                        err_inc  = 1'b1;
                    end else begin
                        we           = 1'b1;
                        wr_ptr_d     = base_wr + 1'b1;
                        commit_ptr_d = base_wr + 1'b1;
                    end
                end else if (pkt_ovf || full) begin
                    state_d = WR_DISCARD;
                end else begin
                    we       = 1'b1;
                    wr_ptr_d = base_wr + 1'b1;
                    state_d  = WR_IN_PKT;
                end
            end
        end
    end

    always_comb begin
        ovf_sum   = {1'b0, ovf_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, ovf_inc};
        err_sum   = {1'b0, err_cnt_q} + {{CNT_WIDTH{1'b0}}, err_inc};
        ovf_cnt_d = ovf_sum[CNT_WIDTH] ? '1 : ovf_sum[CNT_WIDTH-1:0];
        err_cnt_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        load        = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || out_ready);
        if (load) begin
            out_valid_d = 1'b1;
            out_beat_d  = rd_beat;
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            err_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_cnt_q    <= err_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
        end
    end

    assign in_ready          = 1'b1;
    assign out_valid         = out_valid_q;
    assign out_startofpacket = out_beat_q.sop;
    assign out_endofpacket   = out_beat_q.eop;
    assign out_data          = out_beat_q.data;
    assign out_empty         = out_beat_q.empty;
    assign out_error         = 1'b0;
    assign drop_err_cnt      = err_cnt_q;
    assign drop_ovf_cnt      = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_avalon_pkt_filter.sv
// Scoreboard bench for avalon_pkt_filter: expected beats queued at drive time, popped on output handshake.
`default_nettype none

module tb_avalon_pkt_filter;
    import t2t_pkg::*;

    logic        clk, reset;
    logic        in_valid, in_ready, in_sop, in_eop, in_error;
    logic [63:0] in_data;
    logic [2:0]  in_empty;
    logic        out_valid, out_ready, out_sop, out_eop, out_error;
    logic [63:0] out_data;
    logic [2:0]  out_empty;
    logic [15:0] drop_err_cnt, drop_ovf_cnt;

    avalon_pkt_filter #(.DATA_WIDTH(64), .EMPTY_WIDTH(3), .DEPTH(64), .CNT_WIDTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_data           (in_data),
        .in_empty          (in_empty),
        .in_error          (in_error),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_data          (out_data),
        .out_empty         (out_empty),
        .out_error         (out_error),
        .drop_err_cnt      (drop_err_cnt),
        .drop_ovf_cnt      (drop_ovf_cnt)
    );

    t_av_beat exp_q[$];
    int       n_vec = 0;
    int       n_err = 0;
    logic     rdy_tog = 1'b0;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_tog ? ~out_ready : 1'b1;
        end
    end

    // Output monitor: pops scoreboard on handshake, checks hold-stability during stalls.
    initial begin
        logic     prev_stall;
        t_av_beat prev;
        t_av_beat e;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk_val("stall_valid", 64'(out_valid), 64'd1);
                    chk_val("stall_data", out_data, prev.data);
                    chk_val("stall_ctrl", 64'({out_sop, out_eop, out_empty}),
                            64'({prev.sop, prev.eop, prev.empty}));
                end
                if (out_valid && out_ready) begin
                    chk_val("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk_val("out_data", out_data, e.data);
                        chk_val("out_ctrl", 64'({out_sop, out_eop, out_empty}),
                                64'({e.sop, e.eop, e.empty}));
                        chk_val("out_error", 64'(out_error), 64'd0);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev.data  = out_data;
                prev.empty = out_empty;
                prev.sop   = out_sop;
                prev.eop   = out_eop;
            end
        end
    end

    task automatic drive_beat(input logic sop, input logic eop, input logic [63:0] d,
                              input logic [2:0] e, input logic err);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        in_empty = e;
        in_error = err;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [63:0] base, input logic [63:0] step,
                            input logic [2:0] e, input logic err, input logic push);
        t_av_beat b;
        for (int i = 0; i < len; i++) begin
            b.data  = base + step * 64'(i);
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = b.eop ? e : 3'd0;
            if (push) exp_q.push_back(b);
            drive_beat(b.sop, b.eop, b.data, b.empty, b.eop ? err : 1'b0);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk_val("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_empty = '0; in_error = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_valid", 64'(out_valid), 64'd0);
        chk_val("rst_data", out_data, 64'd0);
        chk_val("rst_ctrl", 64'({out_sop, out_eop, out_empty}), 64'd0);
        chk_val("rst_cnts", 64'({drop_err_cnt, drop_ovf_cnt}), 64'd0);
        chk_val("in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Good 3-beat packet and its first-beat latency after the eop edge.
        send_pkt(3, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 3'd5, 1'b0, 1'b1);
        chk_val("lat_eop_edge", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk_val("lat_next_edge", 64'({out_valid, out_sop}), 64'b11);
        drain();
        chk_val("t1_cnts", 64'({drop_err_cnt, drop_ovf_cnt}), 64'd0);

        send_pkt(3, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 3'd5, 1'b1, 1'b0);
        drain();
        chk_val("t2_err_cnt", 64'(drop_err_cnt), 64'd1);
        chk_val("t2_ovf_cnt", 64'(drop_ovf_cnt), 64'd0);

        send_pkt(70, 64'hA000_0000_0000_0000, 64'd1, 3'd0, 1'b0, 1'b0);
        send_pkt(2, 64'hB000_0000_0000_0000, 64'd3, 3'd2, 1'b0, 1'b1);
        drain();
        chk_val("t3_ovf_cnt", 64'(drop_ovf_cnt), 64'd1);

        drive_beat(1'b1, 1'b0, 64'hDEAD_0000_0000_0001, 3'd0, 1'b0);
        drive_beat(1'b0, 1'b0, 64'hDEAD_0000_0000_0002, 3'd0, 1'b0);
        send_pkt(4, 64'hC000_0000_0000_0000, 64'd5, 3'd7, 1'b0, 1'b1);
        drive_beat(1'b0, 1'b0, 64'hBAD0_0000_0000_0001, 3'd0, 1'b0);
        drive_beat(1'b0, 1'b1, 64'hBAD0_0000_0000_0002, 3'd1, 1'b0);
        drain();
        chk_val("t4_ovf_cnt", 64'(drop_ovf_cnt), 64'd2);
        chk_val("t4_err_cnt", 64'(drop_err_cnt), 64'd1);

        rdy_tog = 1'b1;
        for (int p = 0; p < 4; p++) begin
            send_pkt(16, 64'hD000_0000_0000_0000 + 64'(p * 256), 64'd1, 3'(p), 1'b0, 1'b1);
        end
        drain();
        rdy_tog = 1'b0;
        chk_val("t5_ovf_cnt", 64'(drop_ovf_cnt), 64'd2);
        chk_val("t5_err_cnt", 64'(drop_err_cnt), 64'd1);

        for (int i = 0; i < 5; i++) begin
            drive_beat(i == 0, 1'b0, 64'hE000_0000_0000_0000 + 64'(i), 3'd0, 1'b0);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_val("t6_rst_cnts", 64'({drop_err_cnt, drop_ovf_cnt}), 64'd0);
        chk_val("t6_rst_valid", 64'(out_valid), 64'd0);
        send_pkt(1, 64'hF00D_F00D_F00D_F00D, 64'd0, 3'd4, 1'b0, 1'b1);
        drain();
        chk_val("t6_cnts", 64'({drop_err_cnt, drop_ovf_cnt}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
